// File: rtl/div_ratio_ctrl.sv
// Divider ratio controller: gate/load/settle ratio changes so the divided clock never runts; all outputs registered, one-edge latency.
// Optional raw-ratio configuration (i_cfg_direct) is compiled in with RATIO_DIRECT_EN; configs arriving mid-sequence are dropped with o_cfg_err.
module div_ratio_ctrl #(
  parameter int unsigned GUARD_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  RST_RATIO  = 8'd1
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_cfg_valid,
  input  logic [7:0] i_cfg_data,
`ifdef RATIO_DIRECT_EN
  input  logic       i_cfg_direct,
`endif
  output logic [7:0] o_div_ratio,
  output logic       o_clk_en,
  output logic       o_busy,
  output logic       o_cfg_err
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RUN,
    ST_GATE,
    ST_LOAD,
    ST_SETTLE
  } state_t;

  localparam logic [3:0] GUARD_LAST  = 4'(GUARD_CYC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic [7:0] ratio_nxt;
  logic       err_nxt;
  logic       cfg_ok;
  logic [7:0] cfg_ratio;

  always_comb begin
    cfg_ok    = 1'b0;
    cfg_ratio = 8'd0;
`ifdef RATIO_DIRECT_EN
    if (i_cfg_direct) begin
      cfg_ok    = (i_cfg_data != 8'd0);
      cfg_ratio = i_cfg_data;
    end else begin
`else
    begin
`endif
      case (i_cfg_data)
        8'd32:   begin cfg_ok = 1'b1; cfg_ratio = 8'd1; end
        8'd16:   begin cfg_ok = 1'b1; cfg_ratio = 8'd2; end
        8'd8:    begin cfg_ok = 1'b1; cfg_ratio = 8'd4; end
        8'd4:    begin cfg_ok = 1'b1; cfg_ratio = 8'd8; end
        default: begin cfg_ok = 1'b0; cfg_ratio = 8'd0; end
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    ratio_nxt  = o_div_ratio;
    err_nxt    = 1'b0;
    case (state)
      ST_OFF: begin
        if (i_en) state_nxt = ST_RUN;
        if (i_cfg_valid) begin
          if (cfg_ok) ratio_nxt = cfg_ratio;
          else        err_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          // enable loss wins; a coincident config is applied ungated since the clock stops anyway
          state_nxt = ST_OFF;
          if (i_cfg_valid) begin
            if (cfg_ok) ratio_nxt = cfg_ratio;
            else        err_nxt   = 1'b1;
          end
        end else if (i_cfg_valid) begin
          if (!cfg_ok) begin
            err_nxt = 1'b1;
          end else if (cfg_ratio != o_div_ratio) begin
            shadow_nxt = cfg_ratio;
            cnt_nxt    = 4'd0;
            state_nxt  = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        err_nxt = i_cfg_valid;
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_LOAD;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_LOAD: begin
        err_nxt   = i_cfg_valid;
        ratio_nxt = shadow;
        cnt_nxt   = 4'd0;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        err_nxt = i_cfg_valid;
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = i_en ? ST_RUN : ST_OFF;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_OFF;
      cnt         <= 4'd0;
      shadow      <= RST_RATIO;
      o_div_ratio <= RST_RATIO;
      o_clk_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shadow      <= shadow_nxt;
      o_div_ratio <= ratio_nxt;
      o_clk_en    <= (state_nxt == ST_RUN);
      o_busy      <= (state_nxt == ST_GATE) || (state_nxt == ST_LOAD) || (state_nxt == ST_SETTLE);
      o_cfg_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: stimulus queues per-edge expected outputs, a monitor compares after each edge.
module tb_div_ratio_ctrl;

  logic       i_ref_clk = 1'b0;
  logic       i_rst_n   = 1'b0;
  logic       i_en      = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic [7:0] i_cfg_data  = 8'd0;
`ifdef RATIO_DIRECT_EN
  logic       i_cfg_direct = 1'b0;
`endif
  logic [7:0] o_div_ratio;
  logic       o_clk_en;
  logic       o_busy;
  logic       o_cfg_err;

  div_ratio_ctrl dut (
    .i_ref_clk   (i_ref_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_data  (i_cfg_data),
`ifdef RATIO_DIRECT_EN
    .i_cfg_direct(i_cfg_direct),
`endif
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en),
    .o_busy      (o_busy),
    .o_cfg_err   (o_cfg_err)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  typedef struct {
    int         tag;
    logic [7:0] ratio;
    logic       ce;
    logic       busy;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t async_q[$];
  int   edge_n   = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input int tag, input int r, input int ce, input int b, input int e,
                              input string nm);
    exp_t x;
    x.tag   = tag;
    x.ratio = r[7:0];
    x.ce    = (ce != 0);
    x.busy  = (b != 0);
    x.err   = (e != 0);
    x.name  = nm;
    return x;
  endfunction

  // expected outputs observed just after edge 'tag'; kept sorted by tag
  task automatic exp_at(input int tag, input int r, input int ce, input int b, input int e,
                        input string nm);
    int i;
    i = 0;
    while (i < exp_q.size() && exp_q[i].tag <= tag) i++;
    exp_q.insert(i, mk(tag, r, ce, b, e, nm));
  endtask

  task automatic check(input exp_t x);
    checks++;
    if ({o_div_ratio, o_clk_en, o_busy, o_cfg_err} !== {x.ratio, x.ce, x.busy, x.err}) begin
      failures++;
      $display("FAIL %s edge=%0d: got ratio=%0d clk_en=%b busy=%b err=%b, want ratio=%0d clk_en=%b busy=%b err=%b",
               x.name, x.tag, o_div_ratio, o_clk_en, o_busy, o_cfg_err, x.ratio, x.ce, x.busy, x.err);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge i_ref_clk);
      edge_n++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].tag <= edge_n) begin
        x = exp_q.pop_front();
        check(x);
      end
    end
  end

  initial begin : async_monitor
    exp_t x;
    forever begin
      @(negedge i_rst_n);
      #1;
      if (async_q.size() > 0) begin
        x = async_q.pop_front();
        check(x);
      end
    end
  end

  // returns at the falling edge just before edge s, so inputs set now are sampled at edge s
  task automatic at_edge(input int s);
    while (edge_n < s - 1) @(negedge i_ref_clk);
  endtask

  task automatic cfg(input int s, input int d);
    at_edge(s);
`ifdef RATIO_DIRECT_EN
    i_cfg_direct = 1'b0;
`endif
    i_cfg_valid = 1'b1;
    i_cfg_data  = d[7:0];
    @(negedge i_ref_clk);
    i_cfg_valid = 1'b0;
  endtask

`ifdef RATIO_DIRECT_EN
  task automatic cfg_dir(input int s, input int d);
    at_edge(s);
    i_cfg_direct = 1'b1;
    i_cfg_valid  = 1'b1;
    i_cfg_data   = d[7:0];
    @(negedge i_ref_clk);
    i_cfg_valid  = 1'b0;
    i_cfg_direct = 1'b0;
  endtask
`endif

  initial begin : stimulus
    exp_at(1, 1, 0, 0, 0, "reset_state");
    exp_at(2, 1, 0, 0, 0, "idle_off");
    @(negedge i_ref_clk);
    i_rst_n = 1'b1;

    exp_at(3, 1, 1, 0, 0, "en_rise");
    at_edge(3);
    i_en = 1'b1;

    // gate/load/settle with prescale 8 -> ratio 4
    exp_at(10, 1, 1, 0, 0, "run_idle");
    exp_at(11, 1, 0, 1, 0, "gate_start");
    exp_at(15, 1, 0, 1, 0, "load_cycle");
    exp_at(16, 4, 0, 1, 0, "ratio_loaded");
    exp_at(17, 4, 0, 1, 0, "settle_end");
    exp_at(18, 4, 1, 0, 0, "run_resume");
    cfg(11, 8);

    exp_at(21, 4, 1, 0, 1, "bad_prescale_err");
    exp_at(22, 4, 1, 0, 0, "err_one_cycle");
    cfg(21, 12);

    // config arriving mid-sequence is rejected, sequence continues
    exp_at(25, 4, 0, 1, 0, "gate2");
    exp_at(27, 4, 0, 1, 1, "busy_reject");
    exp_at(28, 4, 0, 1, 0, "busy_err_clear");
    exp_at(30, 2, 0, 1, 0, "ratio2_loaded");
    exp_at(32, 2, 1, 0, 0, "run2");
    cfg(25, 16);
    cfg(27, 8);

    exp_at(34, 2, 1, 0, 0, "noop_same_ratio");
    exp_at(35, 2, 1, 0, 0, "noop_stay_run");
    cfg(34, 16);

    // enable dropped during GATE: sequence completes, then OFF
    exp_at(40, 2, 0, 1, 0, "gate3");
    exp_at(45, 8, 0, 1, 0, "load_after_en_drop");
    exp_at(46, 8, 0, 1, 0, "settle3");
    exp_at(47, 8, 0, 0, 0, "off_after_seq");
    exp_at(49, 8, 0, 0, 0, "off_hold");
    cfg(40, 4);
    at_edge(41);
    i_en = 1'b0;

    exp_at(50, 1, 0, 0, 0, "off_load_ungated");
    cfg(50, 32);

    exp_at(52, 1, 1, 0, 0, "en_rise2");
    at_edge(52);
    i_en = 1'b1;

    exp_at(55, 8, 0, 0, 0, "en_fall_with_cfg");
    exp_at(56, 8, 0, 0, 0, "en_fall_stay_off");
    at_edge(55);
    i_en = 1'b0;
    cfg(55, 4);

    exp_at(58, 8, 0, 0, 1, "off_reject_zero");
    cfg(58, 0);

    // reset asserted mid-SETTLE
    exp_at(60, 8, 1, 0, 0, "en_rise3");
    at_edge(60);
    i_en = 1'b1;
    exp_at(62, 8, 0, 1, 0, "gate4");
    exp_at(67, 2, 0, 1, 0, "settle4");
    cfg(62, 16);
    async_q.push_back(mk(67, 1, 0, 0, 0, "async_reset"));
    exp_at(68, 1, 0, 0, 0, "reset_hold");
    at_edge(68);
    i_rst_n = 1'b0;
    exp_at(69, 1, 1, 0, 0, "en_after_reset");
    exp_at(70, 1, 1, 0, 0, "run_after_reset");
    at_edge(69);
    i_rst_n = 1'b1;

`ifdef RATIO_DIRECT_EN
    exp_at(75, 1, 0, 1, 0, "direct_gate");
    exp_at(80, 7, 0, 1, 0, "direct_loaded");
    exp_at(81, 7, 0, 1, 0, "direct_settle");
    exp_at(82, 7, 1, 0, 0, "direct_run");
    cfg_dir(75, 7);
    exp_at(85, 7, 1, 0, 1, "direct_zero_err");
    exp_at(86, 7, 1, 0, 0, "direct_zero_clear");
    cfg_dir(85, 0);
`else
    exp_at(75, 1, 1, 0, 1, "raw7_rejected");
    exp_at(76, 1, 1, 0, 0, "raw7_clear");
    cfg(75, 7);
`endif

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge i_ref_clk);
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d sync and %0d async expectations never checked, want 0",
               exp_q.size(), async_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete, edge=%0d", edge_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
